// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Single-outstanding load/store sequencer between a datapath request port and
// a synchronous word-addressed data memory. One request is taken in IDLE,
// issued to memory for one cycle, (loads only) held for READ_LAT wait cycles
// while the memory produces data, and finished with a one-cycle response.
//
// Optional feature (compile-time macro): MEM_ACCESS_RANGE_CHECK_EN
//   When defined, requests with req_addr >= DEPTH never touch memory and are
//   answered one cycle after acceptance with resp_err=1. When undefined, every
//   address is forwarded unchanged and resp_err is constant 0.
//
// Parameters
//   DEPTH     number of addressable 32-bit words (used by the range check)
//   READ_LAT  memory read latency in clk cycles, 1..7
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous active-high reset
//   req_valid        datapath presents a request
//   req_ready        request accepted on this edge if req_valid is also 1
//   req_write        1 = store, 0 = load
//   req_addr         word index
//   req_wdata        store data
//   resp_valid       one-cycle completion pulse
//   resp_rdata       last load result (held until the next load capture)
//   resp_err         access rejected, qualified by resp_valid
//   mem_address      address to data memory
//   mem_dataInput    write data to data memory
//   mem_writeEnable  active-high write strobe to data memory
//   mem_dataOutput   read data from data memory
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int DEPTH    = 16,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_dataInput,
    output logic        mem_writeEnable,
    input  logic [31:0] mem_dataOutput
);

    if (DEPTH < 1 || READ_LAT < 1 || READ_LAT > 7) begin : g_bad_param
        $error("mem_access_ctrl: DEPTH must be >= 1 and READ_LAT must be 1..7");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Wait counter is loaded with READ_LAT-1 and counts down to 0; the
    // cycle where it reads 0 is the last WAIT cycle (capture cycle).
    localparam logic [2:0] WAIT_LAST = 3'(READ_LAT - 1);

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic        accept;

`ifdef MEM_ACCESS_RANGE_CHECK_EN
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    logic err_q, err_d;
    logic addr_bad;
    assign addr_bad = (req_addr >= DEPTH_W);
`endif

    // rst gates ready combinationally so no request can be taken while the
    // block is held in reset.
    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
`ifdef MEM_ACCESS_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
`ifdef MEM_ACCESS_RANGE_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
`ifdef MEM_ACCESS_RANGE_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d = req_write;
                    cnt_d   = WAIT_LAST;
`ifdef MEM_ACCESS_RANGE_CHECK_EN
                    err_d = addr_bad;
                    if (addr_bad) begin
                        // Rejected: memory port keeps its previous values.
                        state_d = RESP;
                    end else begin
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        state_d = ISSUE;
                    end
`else
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE: begin
                state_d = write_q ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    rdata_d = mem_dataOutput;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All outputs derive from async-reset registers, so reset clears them
    // (including the write strobe) without waiting for a clock edge.
    assign mem_writeEnable = (state_q == ISSUE) && write_q;
    assign mem_address     = addr_q;
    assign mem_dataInput   = wdata_q;
    assign resp_valid      = (state_q == RESP);
    assign resp_rdata      = rdata_q;
`ifdef MEM_ACCESS_RANGE_CHECK_EN
    assign resp_err        = resp_valid && err_q;
`else
    assign resp_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // ---------------- DUT 1 : READ_LAT = 1 ----------------
    logic        v1 = 1'b0, w1 = 1'b0;
    logic [31:0] a1 = '0, d1 = '0;
    logic        req_ready1, resp_valid1, resp_err1, mem_we1;
    logic [31:0] resp_rdata1, mem_address1, mem_dataInput1, mem_dout1;

    mem_access_ctrl #(.DEPTH(16), .READ_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(v1), .req_ready(req_ready1), .req_write(w1),
        .req_addr(a1), .req_wdata(d1),
        .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_err(resp_err1),
        .mem_address(mem_address1), .mem_dataInput(mem_dataInput1),
        .mem_writeEnable(mem_we1), .mem_dataOutput(mem_dout1)
    );

    // ---------------- DUT 3 : READ_LAT = 3 ----------------
    logic        v3 = 1'b0, w3 = 1'b0;
    logic [31:0] a3 = '0, d3 = '0;
    logic        req_ready3, resp_valid3, resp_err3, mem_we3;
    logic [31:0] resp_rdata3, mem_address3, mem_dataInput3, mem_dout3;

    mem_access_ctrl #(.DEPTH(16), .READ_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(v3), .req_ready(req_ready3), .req_write(w3),
        .req_addr(a3), .req_wdata(d3),
        .resp_valid(resp_valid3), .resp_rdata(resp_rdata3), .resp_err(resp_err3),
        .mem_address(mem_address3), .mem_dataInput(mem_dataInput3),
        .mem_writeEnable(mem_we3), .mem_dataOutput(mem_dout3)
    );

    // Memory models: 32 words, reset to a known pattern, combinational read.
    logic [31:0] mem1 [0:31];
    logic [31:0] mem3 [0:31];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem1[i] <= 32'h1000_0000 + 32'(i);
        end else if (mem_we1 && mem_address1 < 32) begin
            mem1[mem_address1[4:0]] <= mem_dataInput1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem3[i] <= 32'h3000_0000 + 32'(i);
        end else if (mem_we3 && mem_address3 < 32) begin
            mem3[mem_address3[4:0]] <= mem_dataInput3;
        end
    end

    assign mem_dout1 = (mem_address1 < 32) ? mem1[mem_address1[4:0]] : 32'hBADB_AD00;
    assign mem_dout3 = (mem_address3 < 32) ? mem3[mem_address3[4:0]] : 32'hBADB_AD00;

    logic [99:0] outs1, outs3;
    assign outs1 = {req_ready1, resp_valid1, resp_rdata1, resp_err1,
                    mem_address1, mem_dataInput1, mem_we1};
    assign outs3 = {req_ready3, resp_valid3, resp_rdata3, resp_err3,
                    mem_address3, mem_dataInput3, mem_we3};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One complete transaction on DUT 1 with its expected results.
    task automatic do_req(input string name, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd,
                          input logic exp_err, input int exp_lat);
        int          n;
        int          lat;
        int          wec;
        logic [31:0] wea, wed;
        logic        errbad;
        n = 0; lat = 0; wec = 0; wea = '0; wed = '0; errbad = 1'b0;
        @(negedge clk);
        while (!req_ready1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ready"}, req_ready1, 1);
        v1 = 1'b1; w1 = w; a1 = a; d1 = d;
        @(posedge clk);
        do begin
            @(negedge clk);
            v1 = 1'b0;
            lat++;
            if (lat == 1) chk({name, "_busy"}, req_ready1, 0);
            if (mem_we1) begin
                wec++;
                wea = mem_address1;
                wed = mem_dataInput1;
            end
            if (resp_err1 && !resp_valid1) errbad = 1'b1;
        end while (!resp_valid1 && lat < 20);
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_rdata"}, resp_rdata1, exp_rd);
        chk({name, "_err"}, resp_err1, exp_err);
        chk({name, "_we_cnt"}, wec, (w && !exp_err) ? 1 : 0);
        if (w && !exp_err) begin
            chk({name, "_we_addr"}, wea, a);
            chk({name, "_we_data"}, wed, d);
        end
        if (!exp_err) chk({name, "_mem_addr"}, mem_address1, a);
        chk({name, "_err_unqualified"}, errbad, 0);
        @(negedge clk);
        chk({name, "_pulse_end"}, resp_valid1, 0);
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic        err;
        int          lat;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_t, second_t, rdy_low, n_resp, we3_cnt;
        logic [31:0] first_d, second_d;
        logic        rdy_at6;

        // write, addr, wdata, expected rdata, expected err, expected latency
        tbl[0] = '{1'b1, 32'd3,  32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2};
        tbl[1] = '{1'b0, 32'd3,  32'h0,         32'hDEAD_BEEF, 1'b0, 3};
        tbl[2] = '{1'b0, 32'd5,  32'h0,         32'h1000_0005, 1'b0, 3};
        tbl[3] = '{1'b1, 32'd5,  32'h1234_5678, 32'h1000_0005, 1'b0, 2};
        tbl[4] = '{1'b0, 32'd5,  32'h0,         32'h1234_5678, 1'b0, 3};
        tbl[5] = '{1'b1, 32'd15, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 2};
        tbl[6] = '{1'b0, 32'd15, 32'h0,         32'hFFFF_FFFF, 1'b0, 3};
        tbl[7] = '{1'b0, 32'd0,  32'h0,         32'h1000_0000, 1'b0, 3};
`ifdef MEM_ACCESS_RANGE_CHECK_EN
        tbl[8]  = '{1'b0, 32'd16, 32'h0,         32'h1000_0000, 1'b1, 1};
        tbl[9]  = '{1'b1, 32'd16, 32'hCAFE_F00D, 32'h1000_0000, 1'b1, 1};
        tbl[10] = '{1'b0, 32'd16, 32'h0,         32'h1000_0000, 1'b1, 1};
`else
        tbl[8]  = '{1'b0, 32'd16, 32'h0,         32'h1000_0010, 1'b0, 3};
        tbl[9]  = '{1'b1, 32'd16, 32'hCAFE_F00D, 32'h1000_0010, 1'b0, 2};
        tbl[10] = '{1'b0, 32'd16, 32'h0,         32'hCAFE_F00D, 1'b0, 3};
`endif

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs1", outs1, 0);
        chk("reset_outs3", outs3, 0);
        rst = 1'b0;
        #1;
        chk("reset_ready1", req_ready1, 1);
        chk("reset_ready3", req_ready3, 1);

        // Table-driven transactions on DUT 1
        for (int i = 0; i < 11; i++) begin
            do_req($sformatf("v%0d", i), tbl[i].w, tbl[i].a, tbl[i].d,
                   tbl[i].rd, tbl[i].err, tbl[i].lat);
        end

        // Back-to-back loads on DUT 3 with req_valid held high throughout
        first_t = 0; second_t = 0; rdy_low = 0; n_resp = 0; we3_cnt = 0;
        first_d = '0; second_d = '0; rdy_at6 = 1'b0;
        @(negedge clk);
        v3 = 1'b1; w3 = 1'b0; a3 = 32'd0;
        chk("b2b_ready0", req_ready3, 1);
        @(posedge clk);
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) a3 = 32'd15;
            if (n == 7) v3 = 1'b0;
            if (n <= 5 && !req_ready3) rdy_low++;
            if (n == 6) rdy_at6 = req_ready3;
            if (mem_we3) we3_cnt++;
            if (resp_valid3) begin
                n_resp++;
                if (first_t == 0) begin
                    first_t = n; first_d = resp_rdata3;
                end else begin
                    second_t = n; second_d = resp_rdata3;
                end
            end
        end
        chk("b2b_ready_low", rdy_low, 5);
        chk("b2b_ready_back", rdy_at6, 1);
        chk("b2b_first_lat", first_t, 5);
        chk("b2b_first_data", first_d, 32'h3000_0000);
        chk("b2b_second_lat", second_t, 11);
        chk("b2b_second_data", second_d, 32'h3000_000F);
        chk("b2b_resp_count", n_resp, 2);
        chk("b2b_no_we", we3_cnt, 0);

        // Reset pulsed during store ISSUE
        @(negedge clk);
        v1 = 1'b1; w1 = 1'b1; a1 = 32'd7; d1 = 32'h0000_0077;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        chk("rst_issue_we_before", mem_we1, 1);
        rst = 1'b1;
        #1;
        chk("rst_issue_outs_async", outs1, 0);
        @(negedge clk);
        chk("rst_issue_outs_held", outs1, 0);
        rst = 1'b0;
        #1;
        chk("rst_issue_ready_after", req_ready1, 1);
        n_resp = 0; we3_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid1) n_resp++;
            if (mem_we1) we3_cnt++;
        end
        chk("rst_issue_no_resp", n_resp, 0);
        chk("rst_issue_no_we", we3_cnt, 0);
        do_req("rst_issue_next", 1'b0, 32'd7, 32'h0, 32'h1000_0007, 1'b0, 3);

        // Reset pulsed during load WAIT
        @(negedge clk);
        v1 = 1'b1; w1 = 1'b0; a1 = 32'd9; d1 = 32'h0;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_wait_in_wait", {mem_address1, mem_we1, resp_valid1, req_ready1},
            {32'd9, 1'b0, 1'b0, 1'b0});
        rst = 1'b1;
        #1;
        chk("rst_wait_outs_async", outs1, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_wait_ready_after", req_ready1, 1);
        n_resp = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid1) n_resp++;
        end
        chk("rst_wait_no_resp", n_resp, 0);
        do_req("rst_wait_next", 1'b0, 32'd9, 32'h0, 32'h1000_0009, 1'b0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clk is the single clock, and rst is an asynchronous, active-high reset.
REQ-002 Parameter DEPTH, default 16, SHALL set the number of addressable 32-bit words.
REQ-003 Parameter READ_LAT, default 1, range 1..7, SHALL set the memory read latency in clk cycles.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req_valid  input  1  datapath presents an access request.
REQ-007 req_ready  output  1  block accepts a request this cycle.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  word index.
REQ-010 req_wdata  input  32  store data.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  load result.
REQ-013 resp_err  output  1  access rejected; qualified by resp_valid.
REQ-014 mem_address  output  32  address to data memory.
REQ-015 mem_dataInput  output  32  write data to data memory.
REQ-016 mem_writeEnable  output  1  active-high write strobe to data memory.
REQ-017 mem_dataOutput  input  32  read data from data memory.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-019 req_ready SHALL equal (state==IDLE) AND NOT rst; a request SHALL be accepted only on the clk edge where req_valid AND req_ready are both 1.
REQ-020 On acceptance the block SHALL latch req_write, req_addr and req_wdata, then go IDLE->ISSUE; req_valid in any other state SHALL be ignored.
REQ-021 In ISSUE, mem_address SHALL drive the latched address; for a store, mem_writeEnable=1 for exactly that cycle, mem_dataInput=latched wdata, and next state = RESP.
REQ-022 For a load, ISSUE->WAIT; WAIT SHALL last READ_LAT cycles, with mem_address held; on its last cycle mem_dataOutput SHALL be captured into resp_rdata, then WAIT->RESP.
REQ-023 In RESP, resp_valid SHALL be 1 for exactly one cycle, then RESP->IDLE; a store SHALL leave resp_rdata unchanged.
REQ-024 Latency from accept edge to resp_valid SHALL be 2 cycles for a store and 2+READ_LAT cycles for a load; back-to-back throughput SHALL be one request per 3 (store) or 3+READ_LAT (load) cycles.
REQ-025 mem_writeEnable SHALL be 0 in every state except store-ISSUE; mem_address and mem_dataInput SHALL hold the last latched values outside ISSUE/WAIT.
REQ-026 resp_rdata SHALL hold its value until the next load capture or reset; resp_err SHALL be 0 except during an error RESP.

Reset
REQ-027 While rst=1, every output SHALL be 0 (req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_dataInput, mem_writeEnable), and the state SHALL be IDLE.
REQ-028 rst asserted mid-transaction SHALL drop the access immediately, with no resp_valid and mem_writeEnable forced to 0 asynchronously.
REQ-029 req_ready SHALL be 1 on the first clk cycle after rst deasserts.

Configuration
REQ-030 With MEM_ACCESS_RANGE_CHECK_EN defined, an accepted request with req_addr >= DEPTH SHALL skip ISSUE/WAIT, make no memory access, and go directly to RESP with resp_err=1, resp_rdata unchanged, at latency 1.
REQ-031 Without MEM_ACCESS_RANGE_CHECK_EN, there SHALL be no range check: every address is forwarded unchanged, and resp_err SHALL be tied to 0.

Verification
REQ-032 Store addr=3, wdata=0xDEADBEEF -> mem_writeEnable=1 for one cycle with mem_address=3 and mem_dataInput=0xDEADBEEF; resp_valid 2 cycles after accept; resp_err=0.
REQ-033 Load addr=3 (memory model returns 0xDEADBEEF), READ_LAT=1 -> resp_valid 3 cycles after accept with resp_rdata=0xDEADBEEF; mem_writeEnable stays 0 throughout.
REQ-034 With READ_LAT=3, back-to-back loads addr 0 then 15 -> req_ready low between them; responses at accept+5 with the correct data and in order.
REQ-035 With the macro defined, load addr=16 -> resp_valid at accept+1 with resp_err=1 and no mem_writeEnable; without the macro, the same stimulus gives mem_address=16 and resp_err=0.
REQ-036 rst pulsed during store-ISSUE or load-WAIT -> all outputs 0 asynchronously and no resp_valid; req_ready=1 on the first cycle after release, and the next load completes normally.
